// File: rtl/adjust_mode_controller_pkg.sv
// Shared definitions for the clock adjust-mode controller: mode encoding,
// field indices and the button priority bit positions.
package adjust_mode_controller_pkg;

    typedef enum logic [0:0] {
        MODE_CLOCK  = 1'b0,
        MODE_ADJUST = 1'b1
    } mode_t;

    localparam int FIELD_CLK_HR  = 0;
    localparam int FIELD_CLK_MIN = 1;
    localparam int FIELD_ALM_HR  = 2;
    localparam int FIELD_ALM_MIN = 3;

    // Bit positions in the request vector; a lower index means a higher priority.
    localparam int BTN_C    = 0;
    localparam int BTN_U    = 1;
    localparam int BTN_D    = 2;
    localparam int BTN_L    = 3;
    localparam int BTN_R    = 4;
    localparam int NUM_BTNS = 5;

    localparam int CNT_W = 6;

endpackage

// File: rtl/adjust_mode_controller_btn_priority_arbiter.sv
// Fixed-priority one-hot select over the five button pulses (C > U > D > L > R).
module btn_priority_arbiter
    import adjust_mode_controller_pkg::*;
(
    input  logic [NUM_BTNS-1:0] req,
    output logic [NUM_BTNS-1:0] grant
);

    // Isolating the lowest set bit gives priority to the centre button at bit 0.
    always_comb begin
        grant = req & (~req + NUM_BTNS'(1));
    end

endmodule

// File: rtl/adjust_mode_controller.sv
// CLOCK/ADJUST sequencer: field selection, inc/dec strobes, alarm arming,
// inactivity timeout and blink phase, all driven by single-cycle button pulses.
module adjust_mode_controller
    import adjust_mode_controller_pkg::*;
#(
    parameter int NUM_FIELDS = 4,
    parameter int TIMEOUT_S  = 10
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_1hz,
    input  logic                          btn_c,
    input  logic                          btn_u,
    input  logic                          btn_d,
    input  logic                          btn_l,
    input  logic                          btn_r,
    output logic                          adjust_mode,
    output logic [$clog2(NUM_FIELDS)-1:0] field_sel,
    output logic [NUM_FIELDS-1:0]         field_onehot,
    output logic                          inc_strobe,
    output logic                          dec_strobe,
    output logic                          alarm_en,
    output logic                          blink
);

    localparam int FIELD_W = $clog2(NUM_FIELDS);

    function automatic logic [FIELD_W-1:0] field_up(input logic [FIELD_W-1:0] f);
        return (f == FIELD_W'(NUM_FIELDS - 1)) ? '0 : f + FIELD_W'(1);
    endfunction

    function automatic logic [FIELD_W-1:0] field_down(input logic [FIELD_W-1:0] f);
        return (f == '0) ? FIELD_W'(NUM_FIELDS - 1) : f - FIELD_W'(1);
    endfunction

    function automatic logic [NUM_FIELDS-1:0] field_decode(input logic [FIELD_W-1:0] f);
        return NUM_FIELDS'(1) << f;
    endfunction

    logic [NUM_BTNS-1:0] btn_req;
    logic [NUM_BTNS-1:0] grant;
    logic                accepted;

    mode_t                mode;
    mode_t                mode_nxt;
    logic [FIELD_W-1:0]   field_nxt;
    logic [NUM_FIELDS-1:0] onehot_nxt;
    logic                 inc_nxt;
    logic                 dec_nxt;
    logic                 alarm_nxt;
    logic                 blink_nxt;
    logic [CNT_W-1:0]     idle_count;
    logic [CNT_W-1:0]     count_nxt;

    always_comb begin
        btn_req        = '0;
        btn_req[BTN_C] = btn_c;
        btn_req[BTN_U] = btn_u;
        btn_req[BTN_D] = btn_d;
        btn_req[BTN_L] = btn_l;
        btn_req[BTN_R] = btn_r;
    end

    btn_priority_arbiter u_arbiter (
        .req   (btn_req),
        .grant (grant)
    );

    assign accepted = |grant;

    always_comb begin
        mode_nxt  = mode;
        field_nxt = field_sel;
        alarm_nxt = alarm_en;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        blink_nxt = blink;
        count_nxt = idle_count;

        if (mode == MODE_CLOCK) begin
            blink_nxt = 1'b0;
            count_nxt = '0;
            if (grant[BTN_C]) begin
                mode_nxt  = MODE_ADJUST;
                field_nxt = FIELD_W'(FIELD_CLK_HR);
            end else if (grant[BTN_U]) begin
                alarm_nxt = ~alarm_en;
            end
        end else begin
            if (accepted) begin
                count_nxt = '0;
                if (grant[BTN_C]) begin
                    mode_nxt = MODE_CLOCK;
                end else if (grant[BTN_U]) begin
                    inc_nxt = 1'b1;
                end else if (grant[BTN_D]) begin
                    dec_nxt = 1'b1;
                end else if (grant[BTN_L]) begin
                    field_nxt = field_down(field_sel);
                end else begin
                    field_nxt = field_up(field_sel);
                end
            end else if (tick_1hz) begin
                // The tick that completes the idle period returns to CLOCK on this edge.
                if (idle_count == CNT_W'(TIMEOUT_S - 1)) begin
                    mode_nxt  = MODE_CLOCK;
                    count_nxt = '0;
                end else begin
                    count_nxt = idle_count + CNT_W'(1);
                end
            end

            if (mode_nxt == MODE_CLOCK) begin
                blink_nxt = 1'b0;
            end else if (tick_1hz) begin
                blink_nxt = ~blink;
            end
        end

        onehot_nxt = (mode_nxt == MODE_ADJUST) ? field_decode(field_nxt) : '0;
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode         <= MODE_CLOCK;
            field_sel    <= '0;
            field_onehot <= '0;
            inc_strobe   <= 1'b0;
            dec_strobe   <= 1'b0;
            alarm_en     <= 1'b0;
            blink        <= 1'b0;
            idle_count   <= '0;
        end else begin
            mode         <= mode_nxt;
            field_sel    <= field_nxt;
            field_onehot <= onehot_nxt;
            inc_strobe   <= inc_nxt;
            dec_strobe   <= dec_nxt;
            alarm_en     <= alarm_nxt;
            blink        <= blink_nxt;
            idle_count   <= count_nxt;
        end
    end

    assign adjust_mode = (mode == MODE_ADJUST);

endmodule
